// File: rtl/rv64g_l2_dir_ctrl.sv
// rtl/rv64g_l2_dir_ctrl.sv - L2 coherence directory request sequencer and round-robin arbiter
module rv64g_l2_dir_ctrl #(
  parameter int SETS  = 256,
  parameter int WAYS  = 16,
  parameter int CORES = 4,
  parameter int REQS  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQS-1:0]               req_valid_i,
  output logic [REQS-1:0]               req_ready_o,
  input  logic [REQS*2-1:0]             req_op_i,
  input  logic [REQS*$clog2(SETS)-1:0]  req_set_i,
  input  logic [REQS*$clog2(WAYS)-1:0]  req_way_i,
  input  logic [REQS*$clog2(CORES)-1:0] req_core_i,
  output logic [$clog2(SETS)-1:0]       dir_rd_set_o,
  input  logic [WAYS-1:0]               dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0]         dir_rd_sharers_i,
  input  logic [WAYS-1:0]               dir_rd_owner_valid_i,
  input  logic [WAYS*$clog2(CORES)-1:0] dir_rd_owner_id_i,
  input  logic [WAYS-1:0]               dir_rd_dirty_i,
  output logic                          dir_we_o,
  output logic [$clog2(SETS)-1:0]       dir_wr_set_o,
  output logic [$clog2(WAYS)-1:0]       dir_wr_way_o,
  output logic                          dir_wr_valid_o,
  output logic [CORES-1:0]              dir_wr_sharers_o,
  output logic                          dir_wr_owner_valid_o,
  output logic [$clog2(CORES)-1:0]      dir_wr_owner_id_o,
  output logic                          dir_wr_dirty_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [((REQS > 1) ? $clog2(REQS) : 1)-1:0] rsp_req_id_o,
  output logic [CORES-1:0]              rsp_probe_mask_o,
  output logic                          rsp_prev_valid_o,
  output logic                          rsp_prev_dirty_o
);
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int CW = $clog2(CORES);
  localparam int RW = (REQS > 1) ? $clog2(REQS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;

  logic [RW-1:0]    rr_q, gnt, id_q;
  logic             any_req;
  logic [1:0]       op_q;
  logic [SW-1:0]    set_q;
  logic [WW-1:0]    way_q;
  logic [CW-1:0]    core_q;

  logic             e_v, e_ov, e_d;
  logic [CORES-1:0] e_sh, core_oh, own_oh, holders;
  logic [CW-1:0]    e_oid;
  logic             n_v, n_ov, n_d;
  logic [CORES-1:0] n_sh, mask_d;
  logic [CW-1:0]    n_oid;

  logic             wr_v_q, wr_ov_q, wr_d_q, prev_v_q, prev_d_q;
  logic [CORES-1:0] wr_sh_q, mask_q;
  logic [CW-1:0]    wr_oid_q;

  // Round-robin pick: first pending requester at or after the pointer
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    for (int i = 0; i < REQS; i++) begin
      if (!any_req && req_valid_i[(int'(rr_q) + i) % REQS]) begin
        any_req = 1'b1;
        gnt     = RW'((int'(rr_q) + i) % REQS);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes; strobes are masked while reset is held
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    dir_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        req_ready_o = REQS'(rst_n) << gnt;
        state_d     = READ;
      end
      READ:  state_d = WRITE;
      WRITE: begin
        dir_we_o = rst_n;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_o = rst_n;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next directory entry and probe mask from the addressed way of the read set
  always_comb begin
    e_v     = dir_rd_valid_i[way_q];
    e_sh    = e_v ? dir_rd_sharers_i[int'(way_q)*CORES +: CORES] : '0;
    e_ov    = e_v & dir_rd_owner_valid_i[way_q];
    e_oid   = e_v ? dir_rd_owner_id_i[int'(way_q)*CW +: CW] : '0;
    e_d     = e_v & dir_rd_dirty_i[way_q];
    core_oh = CORES'(1) << core_q;
    own_oh  = CORES'(1) << e_oid;
    holders = e_sh | (e_ov ? own_oh : '0);
    n_v     = e_v;
    n_sh    = e_sh;
    n_ov    = e_ov;
    n_oid   = e_oid;
    n_d     = e_d;
    mask_d  = '0;
    case (op_q)
      2'd0: begin
        n_v = 1'b1;
        if (e_ov && (e_oid != core_q)) begin
          mask_d = own_oh;
          n_sh   = own_oh | core_oh;
          n_ov   = 1'b0;
          n_d    = 1'b0;
        end else if (!e_ov) begin
          n_sh = e_sh | core_oh;
        end
      end
      2'd1: begin
        mask_d = holders & ~core_oh;
        n_v    = 1'b1;
        n_sh   = '0;
        n_ov   = 1'b1;
        n_oid  = core_q;
        n_d    = 1'b1;
      end
      2'd2: begin
        n_sh = e_sh & ~core_oh;
        if (e_ov && (e_oid == core_q)) begin
          n_ov = 1'b0;
          n_d  = 1'b0;
        end
      end
      default: begin
        mask_d = holders;
        n_v    = 1'b0;
        n_sh   = '0;
        n_ov   = 1'b0;
        n_oid  = '0;
        n_d    = 1'b0;
      end
    endcase
  end

  // Grant capture, rr pointer, and the read-modify result held through write and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= '0;  id_q <= '0;  op_q <= '0;  set_q <= '0;  way_q <= '0;  core_q <= '0;
      wr_v_q <= 1'b0;  wr_sh_q <= '0;  wr_ov_q <= 1'b0;  wr_oid_q <= '0;  wr_d_q <= 1'b0;
      mask_q <= '0;  prev_v_q <= 1'b0;  prev_d_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      rr_q   <= RW'((int'(gnt) + 1) % REQS);
      id_q   <= gnt;
      op_q   <= req_op_i[int'(gnt)*2 +: 2];
      set_q  <= req_set_i[int'(gnt)*SW +: SW];
      way_q  <= req_way_i[int'(gnt)*WW +: WW];
      core_q <= req_core_i[int'(gnt)*CW +: CW];
    end else if (state_q == READ) begin
      wr_v_q   <= n_v;
      wr_sh_q  <= n_sh;
      wr_ov_q  <= n_ov;
      wr_oid_q <= n_oid;
      wr_d_q   <= n_d;
      mask_q   <= mask_d;
      prev_v_q <= e_v;
      prev_d_q <= e_d;
    end
  end

  assign dir_rd_set_o         = set_q;
  assign dir_wr_set_o         = set_q;
  assign dir_wr_way_o         = way_q;
  assign dir_wr_valid_o       = wr_v_q;
  assign dir_wr_sharers_o     = wr_sh_q;
  assign dir_wr_owner_valid_o = wr_ov_q;
  assign dir_wr_owner_id_o    = wr_oid_q;
  assign dir_wr_dirty_o       = wr_d_q;
  assign rsp_req_id_o         = id_q;
  assign rsp_probe_mask_o     = mask_q;
  assign rsp_prev_valid_o     = prev_v_q;
  assign rsp_prev_dirty_o     = prev_d_q;
endmodule

// File: tb/tb_rv64g_l2_dir_ctrl.sv
// tb/tb_rv64g_l2_dir_ctrl.sv - randomized self-checking bench for rv64g_l2_dir_ctrl
module tb_rv64g_l2_dir_ctrl;
  typedef struct packed {
    logic       v;
    logic [3:0] sh;
    logic       ov;
    logic [1:0] oid;
    logic       d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready;
  logic [5:0]  req_op;
  logic [23:0] req_set;
  logic [11:0] req_way;
  logic [5:0]  req_core;
  logic [7:0]  dir_rd_set;
  logic [15:0] rd_v, rd_ov, rd_d;
  logic [63:0] rd_sh;
  logic [31:0] rd_oid;
  logic        dir_we, wr_v, wr_ov, wr_d;
  logic [7:0]  wr_set;
  logic [3:0]  wr_way, wr_sh;
  logic [1:0]  wr_oid;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_mask;
  logic        rsp_pv, rsp_pd;

  ent_t        mem [256][16];
  logic [1:0]  t_op [3];
  logic [7:0]  t_set [3];
  logic [3:0]  t_way [3];
  logic [1:0]  t_core [3];
  int          rr_m;
  int          tests = 0;
  int          fails = 0;

  rv64g_l2_dir_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_set_i(req_set), .req_way_i(req_way), .req_core_i(req_core),
    .dir_rd_set_o(dir_rd_set), .dir_rd_valid_i(rd_v), .dir_rd_sharers_i(rd_sh),
    .dir_rd_owner_valid_i(rd_ov), .dir_rd_owner_id_i(rd_oid), .dir_rd_dirty_i(rd_d),
    .dir_we_o(dir_we), .dir_wr_set_o(wr_set), .dir_wr_way_o(wr_way),
    .dir_wr_valid_o(wr_v), .dir_wr_sharers_o(wr_sh), .dir_wr_owner_valid_o(wr_ov),
    .dir_wr_owner_id_o(wr_oid), .dir_wr_dirty_o(wr_d),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_req_id_o(rsp_id),
    .rsp_probe_mask_o(rsp_mask), .rsp_prev_valid_o(rsp_pv), .rsp_prev_dirty_o(rsp_pd)
  );

  always #5 clk = ~clk;

  // Behavioural directory storage presented on the combinational read port
  always_comb begin
    for (int w = 0; w < 16; w++) begin
      rd_v[w]          = mem[dir_rd_set][w].v;
      rd_sh[w*4 +: 4]  = mem[dir_rd_set][w].sh;
      rd_ov[w]         = mem[dir_rd_set][w].ov;
      rd_oid[w*2 +: 2] = mem[dir_rd_set][w].oid;
      rd_d[w]          = mem[dir_rd_set][w].d;
    end
  end

  function automatic void model(input ent_t e_in, input logic [1:0] op, input logic [1:0] c,
                                output ent_t n, output logic [3:0] mask);
    ent_t e;
    logic [3:0] me, owner, holders;
    e       = e_in.v ? e_in : '0;
    me      = 4'b0001 << c;
    owner   = 4'b0001 << e.oid;
    holders = e.sh | (e.ov ? owner : 4'b0000);
    n       = e;
    mask    = 4'b0000;
    if (op == 2'd0) begin
      n.v = 1'b1;
      if (e.ov && e.oid != c) begin
        mask = owner;  n.sh = owner | me;  n.ov = 1'b0;  n.d = 1'b0;
      end else if (!e.ov) begin
        n.sh = e.sh | me;
      end
    end else if (op == 2'd1) begin
      mask = holders & ~me;
      n = '{v: 1'b1, sh: 4'b0000, ov: 1'b1, oid: c, d: 1'b1};
    end else if (op == 2'd2) begin
      n.sh = e.sh & ~me;
      if (e.ov && e.oid == c) begin
        n.ov = 1'b0;  n.d = 1'b0;
      end
    end else begin
      mask = holders;
      n    = '0;
    end
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.v = 1'b0;  e.sh = 4'($urandom);  e.ov = 1'($urandom);  e.oid = 2'($urandom);  e.d = 1'($urandom);
    case ($urandom_range(0, 2))
      0: e.v = 1'b0;
      1: begin e.v = 1'b1; e.ov = 1'b0; e.d = 1'b0; end
      default: begin e.v = 1'b1; e.sh = 4'b0000; e.ov = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < 3; i++) begin
      t_op[i]   = 2'($urandom);
      t_set[i]  = 8'($urandom_range(0, 3));
      t_way[i]  = 4'($urandom_range(0, 3));
      t_core[i] = 2'($urandom);
    end
  endtask

  // One full transaction from an IDLE cycle, checked cycle by cycle; leaves bench in the next IDLE cycle
  task automatic txn(input logic [2:0] vmask, input int hold, output int g);
    ent_t pe, ne;
    logic [3:0] em;
    int cyc;
    g = -1;
    for (int i = 0; i < 3; i++)
      if (g < 0 && vmask[(rr_m + i) % 3]) g = (rr_m + i) % 3;
    for (int i = 0; i < 3; i++) begin
      req_op[i*2 +: 2] = t_op[i];  req_set[i*8 +: 8] = t_set[i];
      req_way[i*4 +: 4] = t_way[i];  req_core[i*2 +: 2] = t_core[i];
    end
    pe = mem[t_set[g]][t_way[g]];
    model(pe, t_op[g], t_core[g], ne, em);
    req_valid = vmask;
    #1;
    cyc = 0;
    while (req_ready == 3'b000 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    tests++;
    if (req_ready !== (3'b001 << g)) begin
      fails++; $display("FAIL grant: got %b exp %b", req_ready, 3'b001 << g);
    end
    @(negedge clk); #1;
    tests++;
    if (dir_we !== 1'b0 || req_ready !== 3'b000 || dir_rd_set !== t_set[g]) begin
      fails++; $display("FAIL read_cycle: we=%b ready=%b rd_set=%0d exp set %0d", dir_we, req_ready, dir_rd_set, t_set[g]);
    end
    @(negedge clk); #1;
    tests++;
    if (dir_we !== 1'b1 || req_ready !== 3'b000 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL write_strobe: we=%b ready=%b rsp_valid=%b", dir_we, req_ready, rsp_valid);
    end
    tests++;
    if ({wr_set, wr_way, wr_v, wr_sh, wr_ov, wr_oid, wr_d} !== {t_set[g], t_way[g], ne}) begin
      fails++; $display("FAIL write_data: got %h exp %h", {wr_set, wr_way, wr_v, wr_sh, wr_ov, wr_oid, wr_d}, {t_set[g], t_way[g], ne});
    end
    mem[t_set[g]][t_way[g]] = ne;
    tests++;
    if (ne.d && !ne.ov || ne.ov && ne.sh != 4'b0000) begin
      fails++; $display("FAIL invariant: entry %h", ne);
    end
    @(negedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      tests++;
      if (rsp_valid !== 1'b1 || dir_we !== 1'b0 || req_ready !== 3'b000 ||
          {rsp_id, rsp_mask, rsp_pv, rsp_pd} !== {2'(g), em, pe.v, pe.v & pe.d}) begin
        fails++; $display("FAIL response: valid=%b we=%b ready=%b got %h exp %h", rsp_valid, dir_we, req_ready,
                          {rsp_id, rsp_mask, rsp_pv, rsp_pd}, {2'(g), em, pe.v, pe.v & pe.d});
      end
      if (h < hold) begin @(negedge clk); #1; end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || dir_we !== 1'b0) begin
      fails++; $display("FAIL back_to_idle: rsp_valid=%b we=%b", rsp_valid, dir_we);
    end
    rr_m = (g + 1) % 3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;  req_valid = 3'b000;  rsp_ready = 1'b0;
    req_op = '0;  req_set = '0;  req_way = '0;  req_core = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if ({req_ready, dir_we, rsp_valid, dir_rd_set, rsp_id, rsp_mask, rsp_pv, rsp_pd} !== '0 ||
        {wr_set, wr_way, wr_v, wr_sh, wr_ov, wr_oid, wr_d} !== '0) begin
      fails++; $display("FAIL reset_outputs: nonzero output after reset");
    end
    rr_m = 0;
  endtask

  task automatic test_directed();
    int g;
    mem[5][3] = '{v: 1'b0, sh: 4'b1001, ov: 1'b1, oid: 2'd1, d: 1'b1};
    t_op[0] = 2'd0;  t_set[0] = 8'd5;  t_way[0] = 4'd3;  t_core[0] = 2'd2;
    txn(3'b001, 0, g);
    mem[6][1] = '{v: 1'b1, sh: 4'b0000, ov: 1'b1, oid: 2'd1, d: 1'b1};
    t_op[1] = 2'd0;  t_set[1] = 8'd6;  t_way[1] = 4'd1;  t_core[1] = 2'd3;
    txn(3'b010, 0, g);
    mem[7][2] = '{v: 1'b1, sh: 4'b1011, ov: 1'b0, oid: 2'd0, d: 1'b0};
    t_op[2] = 2'd1;  t_set[2] = 8'd7;  t_way[2] = 4'd2;  t_core[2] = 2'd0;
    txn(3'b100, 0, g);
    t_op[0] = 2'd2;  t_set[0] = 8'd7;  t_way[0] = 4'd2;  t_core[0] = 2'd0;
    txn(3'b001, 0, g);
    mem[8][0] = '{v: 1'b1, sh: 4'b0110, ov: 1'b0, oid: 2'd0, d: 1'b0};
    t_op[1] = 2'd3;  t_set[1] = 8'd8;  t_way[1] = 4'd0;  t_core[1] = 2'd1;
    txn(3'b010, 0, g);
    tests++;
    if (mem[8][0] !== '0 || mem[7][2] !== '{v: 1'b1, sh: 4'b0000, ov: 1'b0, oid: 2'd0, d: 1'b0}) begin
      fails++; $display("FAIL directed_state: inval %h release %h", mem[8][0], mem[7][2]);
    end
  endtask

  task automatic test_random();
    int g;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 16; w++) mem[s][w] = rand_ent();
    for (int k = 0; k < 40; k++) begin
      randomize_reqs();
      txn(3'($urandom_range(1, 7)), $urandom_range(0, 2), g);
    end
    req_valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    int cyc;
    randomize_reqs();
    for (int i = 0; i < 3; i++) begin
      req_op[i*2 +: 2] = t_op[i];  req_set[i*8 +: 8] = t_set[i];
      req_way[i*4 +: 4] = t_way[i];  req_core[i*2 +: 2] = t_core[i];
    end
    req_valid = 3'b010;
    #1;
    cyc = 0;
    while (req_ready == 3'b000 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    tests++;
    if (req_ready !== 3'b010) begin
      fails++; $display("FAIL mid_grant: got %b exp 010", req_ready);
    end
    req_valid = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (dir_we !== 1'b0) begin
      fails++; $display("FAIL mid_reset_we: got %b exp 0", dir_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (rsp_valid !== 1'b0 || dir_we !== 1'b0) begin
        fails++; $display("FAIL mid_reset_quiet: rsp_valid=%b we=%b", rsp_valid, dir_we);
      end
      @(negedge clk);
    end
    #1;
    rr_m = 0;
  endtask

  task automatic test_back_to_back();
    int g;
    for (int k = 0; k < 6; k++) begin
      randomize_reqs();
      txn(3'b111, (k == 0) ? 5 : 0, g);
      tests++;
      if (g != k % 3) begin
        fails++; $display("FAIL rr_order: txn %0d got %0d exp %0d", k, g, k % 3);
      end
    end
    req_valid = 3'b000;
  endtask

  initial begin
    for (int s = 0; s < 256; s++)
      for (int w = 0; w < 16; w++) mem[s][w] = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv64g_l2_dir_ctrl.md
Name: rv64g_l2_dir_ctrl

Overview:
- Sequencer and arbiter for the L2 coherence directory (whole-set read port, single-way write port).
- Accepts directory transactions from REQS requesters (acquire handler, release handler, eviction engine), grants one at a time round-robin and reads the target set.
- Computes the next directory entry for the addressed way, writes it back, and returns the probe mask the requester must issue to L1 caches.

Parameters:
SETS, 256, directory sets
WAYS, 16, directory ways
CORES, 4, cores tracked per entry
REQS, 3, number of requesters

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
req_valid_i  in  REQS  request pending per requester
req_ready_o  out  REQS  one-hot grant/accept pulse
req_op_i  in  REQS*2  op per requester: 0 ACQ_S, 1 ACQ_U, 2 RELEASE, 3 INVAL
req_set_i  in  REQS*$clog2(SETS)  target set
req_way_i  in  REQS*$clog2(WAYS)  target way (chosen by tag logic upstream)
req_core_i  in  REQS*$clog2(CORES)  requesting core
dir_rd_set_o  out  $clog2(SETS)  directory read set
dir_rd_valid_i  in  WAYS  directory read data
dir_rd_sharers_i  in  WAYS*CORES  directory read data
dir_rd_owner_valid_i  in  WAYS  directory read data
dir_rd_owner_id_i  in  WAYS*$clog2(CORES)  directory read data
dir_rd_dirty_i  in  WAYS  directory read data
dir_we_o  out  1  directory write enable
dir_wr_set_o  out  $clog2(SETS)  write set
dir_wr_way_o  out  $clog2(WAYS)  write way
dir_wr_valid_o  out  1  write data
dir_wr_sharers_o  out  CORES  write data
dir_wr_owner_valid_o  out  1  write data
dir_wr_owner_id_o  out  $clog2(CORES)  write data
dir_wr_dirty_o  out  1  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_req_id_o  out  $clog2(REQS)  requester that owns this response
rsp_probe_mask_o  out  CORES  cores to probe
rsp_prev_valid_o  out  1  entry valid before update
rsp_prev_dirty_o  out  1  entry dirty before update

Behaviour:
- Clock is clk. Reset is synchronous, active-low, on rst_n.
- FSM states: IDLE, READ, WRITE, RESP.
- Reset values: state IDLE; rr pointer 0; all outputs 0, including req_ready_o, dir_we_o and rsp_valid_o.
- IDLE: if any req_valid_i is set, grant the first valid index at or after the rr pointer (wrap modulo REQS).
  - Pulse req_ready_o[g] for one cycle.
  - Latch op, set, way, core and g.
  - Set rr pointer to g+1 (wrap). Go to READ.
  - With no valid requests, the pointer is unchanged.
- READ: drive dir_rd_set_o = latched set. The directory read is combinational, so this cycle:
  - Extract the entry at the latched way.
  - Latch prev fields, next entry and probe mask. Go to WRITE.
- Holders: H = sharers, OR onehot(owner_id) if owner_valid. If prev valid=0, H=0 and the entry is treated as all-zero.
- ACQ_S:
  - If owner_valid and owner_id≠core: mask = onehot(owner); next sharers = onehot(owner)|onehot(core); owner_valid=0; dirty=0.
  - Otherwise, if owner_valid and owner==core: mask = 0; entry unchanged apart from valid=1.
  - Otherwise: mask = 0; sharers |= onehot(core).
  - In all cases valid=1.
- ACQ_U: mask = H & ~onehot(core). Next: valid=1, sharers=0, owner_valid=1, owner_id=core, dirty=1.
- RELEASE: mask = 0. Next: sharers &= ~onehot(core); if owner_valid and owner==core, then owner_valid=0 and dirty=0; valid unchanged.
- INVAL: mask = H. Next entry is all zero.
- Directory invariants must hold on every write: dirty→owner_valid; owner_valid→sharers==0.
- WRITE: dir_we_o=1 for exactly one cycle with the latched set/way/next entry. Go to RESP.
- RESP: rsp_valid_o=1, with fields stable until rsp_ready_i. On handshake go to IDLE; a new grant is possible the following cycle.
- Latency: grant at cycle T, write at T+2, rsp_valid at T+3. Minimum 4 cycles per transaction. At most one transaction in flight, so directory RMW is atomic.
- req_ready_o is never asserted outside IDLE. Requests arriving during a transaction wait, and requester inputs are ignored after the grant.
- dir_rd_set_o must equal the latched set during READ; its value in other states is don't-care but held.
- Reset mid-operation: immediate IDLE, no write issued, no response, pending transaction dropped, rr pointer 0.
- REQS=1: always grant index 0.

Test Plan:
- Reset, then ACQ_S from req0, set 5, way 3, core 2, entry invalid → write valid=1, sharers=0100, owner_valid=0; mask 0000; rsp_prev_valid=0; rsp_valid at T+3.
- Entry {owner_valid=1, owner=1, dirty=1}, ACQ_S core 3 → mask 0010; write sharers=1010, owner_valid=0, dirty=0; rsp_prev_dirty=1.
- Entry sharers=1011, ACQ_U core 0 → mask 1010; write owner_valid=1, owner_id=0, sharers=0, dirty=1.
- RELEASE by owner core 0, then INVAL on entry sharers=0110 → first write owner_valid=0, dirty=0, valid=1; INVAL mask 0110, write all zero.
- All three req_valid held high for 6 transactions → grant order 0,1,2,0,1,2. rsp_ready_i held low 5 cycles → rsp fields stable, no new req_ready_o pulse.
- Assert rst_n=0 during WRITE state → dir_we_o=0 that cycle, no rsp_valid_o, next grant goes to req0.
